// File: rtl/reg_pipe_ce_pkg.sv
// Shared helpers for reg_pipe_ce: width math for the occupancy counter and
// the default reset/flush value of the data stages.
package reg_pipe_ce_pkg;

    localparam int unsigned DEFAULT_INIT = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits++;
        end
        return bits;
    endfunction

    // Counter must hold 0..depth inclusive, and never be narrower than 1 bit.
    function automatic int unsigned count_width(input int unsigned depth);
        int unsigned bits;
        bits = clog2(depth + 1);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: WIDTH-bit data plus valid flop with clock enable,
// synchronous flush, asynchronous active-low reset and selectable clock edge.
module reg_pipe_stage
    import reg_pipe_ce_pkg::*;
#(
    parameter int unsigned      WIDTH       = 2,
    parameter logic [WIDTH-1:0] INIT        = WIDTH'(DEFAULT_INIT),
    parameter bit               CLK_POSEDGE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            data_d  = INIT;
            valid_d = 1'b0;
        end else if (ce_i) begin
            data_d  = d_i;
            valid_d = valid_i;
        end
    end

    // Edge selection is a static choice between two flop flavours, keeping
    // the clock net free of inverting logic.
    if (CLK_POSEDGE) begin : g_pos
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q  <= INIT;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end else begin : g_neg
        always_ff @(negedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q  <= INIT;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_pipe_ce.sv
// Stallable, flushable register pipeline with per-stage valid bits and an
// occupancy count equal to the number of valid stages.
module reg_pipe_ce
    import reg_pipe_ce_pkg::*;
#(
    parameter int unsigned      WIDTH       = 2,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] INIT        = WIDTH'(DEFAULT_INIT),
    parameter bit               CLK_POSEDGE = 1'b1
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESETN,
    input  logic                          CE,
    input  logic                          CLR,
    input  logic [WIDTH-1:0]              I,
    input  logic                          I_VALID,
    output logic [WIDTH-1:0]              O,
    output logic                          O_VALID,
    output logic [count_width(DEPTH)-1:0] COUNT
);

    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q, count_d;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (k == 0) begin : g_head
            assign d_in = I;
            assign v_in = I_VALID;
        end else begin : g_body
            assign d_in = data_q[k-1];
            assign v_in = valid_q[k-1];
        end

        reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .INIT       (INIT),
            .CLK_POSEDGE(CLK_POSEDGE)
        ) u_stage (
            .clk_i  (CLK),
            .rst_ni (ASYNCRESETN),
            .ce_i   (CE),
            .clr_i  (CLR),
            .d_i    (d_in),
            .valid_i(v_in),
            .q_o    (data_q[k]),
            .valid_o(valid_q[k])
        );
    end

    // Tracks popcount(valid) incrementally: entry and exit on the same edge cancel.
    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = '0;
        end else if (CE) begin
            count_d = count_q + CW'(I_VALID) - CW'(valid_q[DEPTH-1]);
        end
    end

    if (CLK_POSEDGE) begin : g_cnt_pos
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) count_q <= '0;
            else              count_q <= count_d;
        end
    end else begin : g_cnt_neg
        always_ff @(negedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) count_q <= '0;
            else              count_q <= count_d;
        end
    end

    assign O       = data_q[DEPTH-1];
    assign O_VALID = valid_q[DEPTH-1];
    assign COUNT   = count_q;

endmodule
